// File: rtl/risc_boot_sequencer.sv
// risc_boot_sequencer: owns the SRAM port and walks the RISC core through clear, load, run and stop
module risc_boot_sequencer #(
    parameter int WORD_SIZE = 8,
    parameter int ADDR_SIZE = 8,
    parameter int CNT_SIZE = 16,
    parameter logic [CNT_SIZE-1:0] RUN_TIMEOUT = 16'hFFFF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 clear_mem,
    input  logic                 abort,
    input  logic [ADDR_SIZE-1:0] load_len,
    input  logic [WORD_SIZE-1:0] in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [ADDR_SIZE-1:0] cpu_addr,
    input  logic [WORD_SIZE-1:0] cpu_data,
    input  logic                 cpu_write,
    input  logic                 cpu_halted,
    input  logic [ADDR_SIZE-1:0] dbg_addr,
    output logic                 cpu_rst_n,
    output logic [ADDR_SIZE-1:0] mem_addr,
    output logic [WORD_SIZE-1:0] mem_data_in,
    output logic                 mem_write,
    output logic                 busy,
    output logic                 done,
    output logic                 timeout,
    output logic [CNT_SIZE-1:0]  cycle_count
);
    typedef enum logic [2:0] {IDLE, CLEAR, LOAD, RUN, STOP} state_t;
    localparam logic [CNT_SIZE-1:0] LAST = RUN_TIMEOUT - CNT_SIZE'(1);
    state_t state;
    logic [ADDR_SIZE-1:0] ptr;
    logic [ADDR_SIZE-1:0] len;
    // Lifecycle state, load pointer, CPU reset and run status
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            ptr         <= '0;
            len         <= '0;
            cpu_rst_n   <= 1'b0;
            done        <= 1'b0;
            timeout     <= 1'b0;
            cycle_count <= '0;
        end else if (abort) begin
            state       <= IDLE;
            ptr         <= '0;
            cpu_rst_n   <= 1'b0;
            done        <= 1'b0;
            timeout     <= 1'b0;
            cycle_count <= '0;
        end else begin
            case (state)
                IDLE, STOP: if (start) begin
                    state       <= clear_mem ? CLEAR : LOAD;
                    len         <= load_len;
                    ptr         <= '0;
                    done        <= 1'b0;
                    timeout     <= 1'b0;
                    cycle_count <= '0;
                end
                CLEAR: begin
                    ptr <= ptr + ADDR_SIZE'(1);
                    if (ptr == '1) state <= LOAD;
                end
                LOAD: if (in_valid) begin
                    ptr <= ptr + ADDR_SIZE'(1);
                    if (ptr == len - ADDR_SIZE'(1)) begin
                        state     <= RUN;
                        cpu_rst_n <= 1'b1;
                    end
                end
                RUN: begin
                    if (cycle_count != '1) cycle_count <= cycle_count + CNT_SIZE'(1);
                    if (cpu_halted) begin
                        state     <= STOP;
                        cpu_rst_n <= 1'b0;
                        done      <= 1'b1;
                    end else if (cycle_count == LAST) begin
                        state     <= STOP;
                        cpu_rst_n <= 1'b0;
                        timeout   <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
    // Memory port mux; abort suppresses any write in the cycle it is raised
    always_comb begin
        in_ready    = state == LOAD && !abort;
        mem_addr    = state == RUN ? cpu_addr : state == STOP ? dbg_addr : ptr;
        mem_data_in = state == RUN ? cpu_data : state == LOAD ? in_data : '0;
        mem_write   = !abort && (state == CLEAR || (state == LOAD && in_valid) || (state == RUN && cpu_write));
        busy        = state != IDLE && state != STOP;
    end
endmodule

// File: tb/tb_risc_boot_sequencer.sv
// tb_risc_boot_sequencer: directed vectors and corner sequences for the boot sequencer
module tb_risc_boot_sequencer;
    logic clk, rst, start, clear_mem, abort, in_valid, cpu_write, cpu_halted;
    logic [7:0] load_len, in_data, cpu_addr, cpu_data, dbg_addr;
    logic in_ready, cpu_rst_n, mem_write, busy, done, timeout;
    logic [7:0] mem_addr, mem_data_in;
    logic [15:0] cycle_count;
    logic t_in_ready, t_cpu_rst_n, t_mem_write, t_busy, t_done, t_timeout;
    logic [7:0] t_mem_addr, t_mem_data_in;
    logic [15:0] t_cycle_count;
    logic [7:0] mem [256];
    int wr_cnt = 0;
    int passed = 0;
    int total = 0;

    risc_boot_sequencer dut (
        .clk(clk), .rst(rst), .start(start), .clear_mem(clear_mem), .abort(abort),
        .load_len(load_len), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .cpu_addr(cpu_addr), .cpu_data(cpu_data), .cpu_write(cpu_write), .cpu_halted(cpu_halted),
        .dbg_addr(dbg_addr), .cpu_rst_n(cpu_rst_n), .mem_addr(mem_addr), .mem_data_in(mem_data_in),
        .mem_write(mem_write), .busy(busy), .done(done), .timeout(timeout), .cycle_count(cycle_count)
    );

    risc_boot_sequencer #(.RUN_TIMEOUT(16'd16)) dut_t (
        .clk(clk), .rst(rst), .start(start), .clear_mem(clear_mem), .abort(abort),
        .load_len(load_len), .in_data(in_data), .in_valid(in_valid), .in_ready(t_in_ready),
        .cpu_addr(cpu_addr), .cpu_data(cpu_data), .cpu_write(cpu_write), .cpu_halted(cpu_halted),
        .dbg_addr(dbg_addr), .cpu_rst_n(t_cpu_rst_n), .mem_addr(t_mem_addr), .mem_data_in(t_mem_data_in),
        .mem_write(t_mem_write), .busy(t_busy), .done(t_done), .timeout(t_timeout), .cycle_count(t_cycle_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) if (mem_write) begin
        mem[mem_addr] <= mem_data_in;
        wr_cnt <= wr_cnt + 1;
    end

    typedef struct {
        logic       start;
        logic [7:0] len;
        logic       valid;
        logic [7:0] data;
        logic       rdy;
        logic       wr;
        logic       bsy;
        logic       crn;
        logic [7:0] addr;
    } vec_t;
    vec_t tbl [9];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    initial begin
        int w0, bad;
        logic [7:0] m40;
        rst = 0; start = 0; clear_mem = 0; abort = 0; load_len = 0; in_data = 0; in_valid = 0;
        cpu_addr = 0; cpu_data = 0; cpu_write = 0; cpu_halted = 0; dbg_addr = 0;
        tbl[0] = '{1'b1, 8'd4, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
        tbl[1] = '{1'b0, 8'd4, 1'b1, 8'h51, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00};
        tbl[2] = '{1'b1, 8'd9, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 8'h01};
        tbl[3] = '{1'b0, 8'd4, 1'b1, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 8'h01};
        tbl[4] = '{1'b0, 8'd4, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 8'h02};
        tbl[5] = '{1'b0, 8'd4, 1'b1, 8'h60, 1'b1, 1'b1, 1'b1, 1'b0, 8'h02};
        tbl[6] = '{1'b0, 8'd4, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 8'h03};
        tbl[7] = '{1'b0, 8'd4, 1'b1, 8'hB0, 1'b1, 1'b1, 1'b1, 1'b0, 8'h03};
        tbl[8] = '{1'b0, 8'd4, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b1, 1'b1, 8'h00};

        repeat (3) @(posedge clk);
        @(negedge clk) rst = 1;
        #1;
        chk("rst_cpu_rst_n", cpu_rst_n, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_timeout", timeout, 0);
        chk("rst_cycle_count", cycle_count, 0);
        chk("rst_mem_write", mem_write, 0);

        w0 = wr_cnt;
        for (int i = 0; i < 9; i++) begin
            @(posedge clk); #1;
            start = tbl[i].start; load_len = tbl[i].len; in_valid = tbl[i].valid; in_data = tbl[i].data;
            @(negedge clk);
            chk($sformatf("row%0d_in_ready", i), in_ready, tbl[i].rdy);
            chk($sformatf("row%0d_mem_write", i), mem_write, tbl[i].wr);
            chk($sformatf("row%0d_busy", i), busy, tbl[i].bsy);
            chk($sformatf("row%0d_cpu_rst_n", i), cpu_rst_n, tbl[i].crn);
            chk($sformatf("row%0d_mem_addr", i), mem_addr, tbl[i].addr);
        end
        chk("load4_writes", wr_cnt - w0, 4);
        chk("load4_mem0", mem[0], 8'h51);
        chk("load4_mem1", mem[1], 8'h00);
        chk("load4_mem2", mem[2], 8'h60);
        chk("load4_mem3", mem[3], 8'hB0);

        for (int i = 2; i <= 30; i++) begin
            @(posedge clk); #1;
            in_valid = 0;
            cpu_write = (i == 5);
            cpu_addr = (i == 5) ? 8'h80 : 8'h00;
            cpu_data = 8'h3C;
            cpu_halted = (i == 30);
            @(negedge clk);
            if (i == 17) begin
                chk("tmo_timeout", t_timeout, 1);
                chk("tmo_done", t_done, 0);
                chk("tmo_cycle_count", t_cycle_count, 16);
                chk("tmo_cpu_rst_n", t_cpu_rst_n, 0);
            end
        end
        @(posedge clk); #1;
        cpu_halted = 0; dbg_addr = 8'h80; cpu_write = 1;
        @(negedge clk);
        chk("halt_done", done, 1);
        chk("halt_timeout", timeout, 0);
        chk("halt_cycle_count", cycle_count, 30);
        chk("halt_cpu_rst_n", cpu_rst_n, 0);
        chk("halt_busy", busy, 0);
        chk("stop_cpu_write_ignored", mem_write, 0);
        chk("dbg_addr", mem_addr, 8'h80);
        chk("dbg_data", mem[mem_addr], 8'h3C);

        @(posedge clk); #1;
        cpu_write = 0; start = 1; clear_mem = 0; load_len = 1;
        @(posedge clk); #1;
        start = 0; in_valid = 1; in_data = 8'h77;
        for (int i = 1; i <= 16; i++) begin
            @(posedge clk); #1;
            in_valid = 0;
            cpu_halted = (i == 16);
        end
        @(posedge clk); #1;
        cpu_halted = 0;
        @(negedge clk);
        chk("tie_done", t_done, 1);
        chk("tie_timeout", t_timeout, 0);
        chk("tie_cycle_count", t_cycle_count, 16);
        chk("tie_main_done", done, 1);
        chk("tie_main_cycle_count", cycle_count, 16);
        chk("tie_mem0", mem[0], 8'h77);

        w0 = wr_cnt;
        @(posedge clk); #1;
        start = 1; clear_mem = 1; load_len = 0;
        bad = 0;
        for (int i = 0; i < 256; i++) begin
            @(posedge clk); #1;
            start = 0;
            @(negedge clk);
            if (!(mem_write === 1'b1 && mem_addr === 8'(i) && mem_data_in === 8'h00 && in_ready === 1'b0 && busy === 1'b1)) bad++;
        end
        chk("clear256_bad_cycles", bad, 0);
        bad = 0;
        for (int i = 0; i < 256; i++) begin
            @(posedge clk); #1;
            in_valid = 1; in_data = 8'(i) ^ 8'h5A;
            @(negedge clk);
            if (!(in_ready === 1'b1 && mem_write === 1'b1 && mem_addr === 8'(i))) bad++;
        end
        chk("load256_bad_cycles", bad, 0);
        @(posedge clk); #1;
        in_valid = 0;
        @(negedge clk);
        chk("load256_run_cpu_rst_n", cpu_rst_n, 1);
        chk("load256_run_in_ready", in_ready, 0);
        chk("clear_load_writes", wr_cnt - w0, 512);
        bad = 0;
        for (int i = 0; i < 256; i++) if (mem[i] !== (8'(i) ^ 8'h5A)) bad++;
        chk("load256_contents", bad, 0);
        @(posedge clk); #1;
        abort = 1;
        @(posedge clk); #1;
        abort = 0;
        @(negedge clk);
        chk("abort_run_busy", busy, 0);
        chk("abort_run_cpu_rst_n", cpu_rst_n, 0);

        @(posedge clk); #1;
        start = 1; clear_mem = 1; load_len = 0;
        for (int i = 0; i < 256; i++) begin
            @(posedge clk); #1;
            start = 0;
        end
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            in_valid = 1; in_data = 8'hC0 + 8'(i);
        end
        @(posedge clk); #1;
        in_data = 8'hEE; abort = 1;
        @(negedge clk);
        chk("abort_load_mem_write", mem_write, 0);
        chk("abort_load_in_ready", in_ready, 0);
        @(posedge clk); #1;
        abort = 0;
        @(negedge clk);
        chk("abort_load_busy", busy, 0);
        chk("idle_in_valid_ignored", mem_write, 0);
        chk("abort_load_mem9", mem[9], 8'hC9);
        chk("abort_load_mem10", mem[10], 8'h00);
        chk("abort_load_mem11", mem[11], 8'h00);

        @(posedge clk); #1;
        in_valid = 0; start = 1; clear_mem = 0; load_len = 1;
        @(posedge clk); #1;
        start = 0; in_valid = 1; in_data = 8'h11;
        @(posedge clk); #1;
        in_valid = 0; cpu_write = 1; cpu_addr = 8'h40; cpu_data = 8'hEE;
        @(negedge clk);
        chk("run_cpu_write_pass", mem_write, 1);
        w0 = wr_cnt;
        m40 = mem[8'h40];
        #1 rst = 0;
        #1;
        chk("arst_mem_write", mem_write, 0);
        chk("arst_cpu_rst_n", cpu_rst_n, 0);
        chk("arst_busy", busy, 0);
        chk("arst_cycle_count", cycle_count, 0);
        @(posedge clk); #1;
        chk("arst_no_write", wr_cnt - w0, 0);
        chk("arst_mem40", mem[8'h40], m40);
        cpu_write = 0;
        @(negedge clk) rst = 1;
        @(posedge clk); #1;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
